mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared op encodings and state type for the HI/LO multiply /
//               divide unit (used by controller and datapath).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == c_OP_MULT) || (op == c_OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == c_OP_DIV) || (op == c_OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : EX-stage HI/LO unit: multi-cycle MULT/MULTU/DIV/DIVU with
//               behavioural arithmetic, single-cycle MTHI/MTLO.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);

  state_e             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [31:0]        r_a,     w_a_nxt;
  logic [31:0]        r_b,     w_b_nxt;
  logic [2:0]         r_op,    w_op_nxt;
  logic [31:0]        r_hi,    w_hi_nxt;
  logic [31:0]        r_lo,    w_lo_nxt;

  // Arithmetic works only on latched operands.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_q_raw;
  logic [31:0] w_r_raw;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_div_signed = (r_op == c_OP_DIV);
  assign w_b_zero     = (r_b == 32'd0);
  assign w_a_mag      = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_b_mag      = r_b[31] ? (~r_b + 32'd1) : r_b;
  assign w_num        = w_div_signed ? w_a_mag : r_a;
  assign w_den        = w_div_signed ? w_b_mag : r_b;
  assign w_q_raw      = w_b_zero ? 32'd0 : (w_num / w_den);
  assign w_r_raw      = w_b_zero ? 32'd0 : (w_num % w_den);
  assign w_quot       = (w_div_signed && (r_a[31] ^ r_b[31])) ? (~w_q_raw + 32'd1) : w_q_raw;
  assign w_rem        = (w_div_signed && r_a[31]) ? (~w_r_raw + 32'd1) : w_r_raw;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (is_mult(op) || is_div(op)) begin
            w_a_nxt     = rs_val;
            w_b_nxt     = rt_val;
            w_op_nxt    = op;
            w_cnt_nxt   = is_mult(op) ? c_MULT_LOAD : c_DIV_LOAD;
            w_state_nxt = S_BUSY;
          end else if (op == c_OP_MTHI) begin
            w_hi_nxt = rs_val;
          end else if (op == c_OP_MTLO) begin
            w_lo_nxt = rs_val;
          end
        end
      end

      S_BUSY: begin
        // Further starts are a protocol error and are dropped here.
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          case (r_op)
            c_OP_MULT: begin
              w_hi_nxt = w_prod_s[63:32];
              w_lo_nxt = w_prod_s[31:0];
            end
            c_OP_MULTU: begin
              w_hi_nxt = w_prod_u[63:32];
              w_lo_nxt = w_prod_u[31:0];
            end
            c_OP_DIV, c_OP_DIVU: begin
              if (!w_b_zero) begin
                w_hi_nxt = w_rem;
                w_lo_nxt = w_quot;
              end
            end
            default: ;
          endcase
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign busy = (r_state == S_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam logic [2:0] c_MULT  = 3'b000;
  localparam logic [2:0] c_MULTU = 3'b001;
  localparam logic [2:0] c_DIV   = 3'b010;
  localparam logic [2:0] c_DIVU  = 3'b011;
  localparam logic [2:0] c_MTHI  = 3'b100;
  localparam logic [2:0] c_MTLO  = 3'b101;
  localparam logic [2:0] c_NOP   = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble inputs; returns at the
  // falling edge after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    op     = c_NOP;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Counts busy cycles (bounded) and flags any hi/lo movement while busy.
  task automatic wait_idle(input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                           output int n, output logic held);
    n    = 0;
    held = 1'b1;
    while (busy && n < 40) begin
      n++;
      if (hi !== hold_hi || lo !== hold_lo) held = 1'b0;
      rs_val = $urandom;
      rt_val = $urandom;
      @(negedge clk);
    end
  endtask

  int   n;
  logic held;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = c_NOP;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_value("reset_busy", {31'd0, busy}, 32'd0);
    check_value("reset_hi", hi, 32'd0);
    check_value("reset_lo", lo, 32'd0);

    issue(c_MTHI, 32'h1234_5678, 32'h0);
    check_value("mthi_hi", hi, 32'h1234_5678);
    check_value("mthi_busy", {31'd0, busy}, 32'd0);
    issue(c_MTLO, 32'h0000_ABCD, 32'h0);
    check_value("mtlo_lo", lo, 32'h0000_ABCD);
    check_value("mtlo_hi", hi, 32'h1234_5678);

    issue(c_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_idle(32'h1234_5678, 32'h0000_ABCD, n, held);
    check_value("mult_cycles", n, 32'd5);
    check_value("mult_hold", {31'd0, held}, 32'd1);
    check_value("mult_hi", hi, 32'hFFFF_FFFF);
    check_value("mult_lo", lo, 32'hFFFF_FFFE);

    issue(c_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(32'hFFFF_FFFF, 32'hFFFF_FFFE, n, held);
    check_value("multu_cycles", n, 32'd5);
    check_value("multu_hold", {31'd0, held}, 32'd1);
    check_value("multu_hi", hi, 32'h0000_0001);
    check_value("multu_lo", lo, 32'hFFFF_FFFE);

    issue(c_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(32'h0000_0001, 32'hFFFF_FFFE, n, held);
    check_value("div_cycles", n, 32'd10);
    check_value("div_hold", {31'd0, held}, 32'd1);
    check_value("div_lo", lo, 32'hFFFF_FFFD);
    check_value("div_hi", hi, 32'hFFFF_FFFF);

    issue(c_DIVU, 32'd7, 32'd0);
    wait_idle(32'hFFFF_FFFF, 32'hFFFF_FFFD, n, held);
    check_value("divu0_cycles", n, 32'd10);
    check_value("divu0_hi", hi, 32'hFFFF_FFFF);
    check_value("divu0_lo", lo, 32'hFFFF_FFFD);

    issue(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(32'hFFFF_FFFF, 32'hFFFF_FFFD, n, held);
    check_value("divovf_lo", lo, 32'h8000_0000);
    check_value("divovf_hi", hi, 32'h0000_0000);

    issue(c_DIVU, 32'd100, 32'd7);
    wait_idle(32'h0000_0000, 32'h8000_0000, n, held);
    check_value("divu_lo", lo, 32'd14);
    check_value("divu_hi", hi, 32'd2);

    issue(c_DIV, 32'd20, 32'hFFFF_FFFD);
    wait_idle(32'd2, 32'd14, n, held);
    check_value("divneg_lo", lo, 32'hFFFF_FFFA);
    check_value("divneg_hi", hi, 32'd2);

    issue(c_NOP, 32'hDEAD_BEEF, 32'd1);
    check_value("nop_busy", {31'd0, busy}, 32'd0);
    check_value("nop_hi", hi, 32'd2);
    check_value("nop_lo", lo, 32'hFFFF_FFFA);

    // A second start while busy must not disturb the running op.
    issue(c_MULTU, 32'd3, 32'd4);
    start  = 1'b1;
    op     = c_MTHI;
    rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    op    = c_NOP;
    wait_idle(32'd2, 32'hFFFF_FFFA, n, held);
    check_value("restart_cycles", n + 1, 32'd5);
    check_value("restart_hi", hi, 32'd0);
    check_value("restart_lo", lo, 32'd12);

    // Reset on busy cycle 4 aborts the divide.
    issue(c_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("rstmid_busy", {31'd0, busy}, 32'd0);
    check_value("rstmid_hi", hi, 32'd0);
    check_value("rstmid_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check_value("rstmid_discard_lo", lo, 32'd0);

    issue(c_MTLO, 32'h0000_0055, 32'd0);
    check_value("post_rst_lo", lo, 32'h0000_0055);
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    op     = c_MTHI;
    rs_val = 32'h0000_0077;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    op    = c_NOP;
    check_value("rst_prio_hi", hi, 32'd0);
    check_value("rst_prio_lo", lo, 32'd0);
    check_value("rst_prio_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
